// File: rtl/full_subtractor.sv
// Full subtractor: a - b - bin with ripple borrow chain.
// Diff/Borr are purely combinational; diff_q/borr_q/out_valid are a
// one-cycle registered copy captured on en.
module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Borr,
    input  logic             en,
    output logic [WIDTH-1:0] diff_q,
    output logic             borr_q,
    output logic             out_valid
);

    // One bit cell of the borrow chain: borrow out of bit i.
    function automatic logic borrow_bit(input logic ai, input logic bi, input logic bri);
        return (~ai & bi) | (~(ai ^ bi) & bri);
    endfunction

    // One bit cell of the difference.
    function automatic logic diff_bit(input logic ai, input logic bi, input logic bri);
        return ai ^ bi ^ bri;
    endfunction

    // Borrow chain; br[0] is the external borrow-in, br[WIDTH] the borrow-out.
    logic [WIDTH:0]   br_p0;
    logic [WIDTH-1:0] diff_p0;

    assign br_p0[0] = bin;

    // ---- stage p0: combinational ripple-borrow subtractor ----
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign diff_p0[i]   = diff_bit(a[i], b[i], br_p0[i]);
        assign br_p0[i + 1] = borrow_bit(a[i], b[i], br_p0[i]);
    end

    assign Diff = diff_p0;
    assign Borr = br_p0[WIDTH];

    // ---- stage p1: registered copy ----
    logic [WIDTH-1:0] diff_p1;
    logic             borr_p1;
    logic             vld_p1;

    // Capture the combinational result on en; reset clears everything and wins over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_p1 <= '0;
            borr_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else if (en) begin
            diff_p1 <= diff_p0;
            borr_p1 <= br_p0[WIDTH];
            vld_p1  <= 1'b1;
        end
    end

    assign diff_q    = diff_p1;
    assign borr_q    = borr_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor (WIDTH=1 and WIDTH=8 instances,
// plus a WIDTH=1 instance with clock stopped and reset held).
module tb_full_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clk_off = 1'b0;
    logic rst_on  = 1'b1;
    logic en_on   = 1'b1;

    // WIDTH=1 instance signals
    logic       a1, b1, bin1, en1, rst1;
    logic       d1, br1, dq1, bq1, v1;
    // Stopped-clock instance outputs (shares a1/b1/bin1)
    logic       d0, br0, dq0, bq0, v0;
    // WIDTH=8 instance signals
    logic [7:0] a8, b8, d8, dq8;
    logic       bin8, en8, rst8, br8, bq8, v8;

    full_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst1), .a(a1), .b(b1), .bin(bin1),
        .Diff(d1), .Borr(br1), .en(en1),
        .diff_q(dq1), .borr_q(bq1), .out_valid(v1)
    );

    full_subtractor #(.WIDTH(1)) u0 (
        .clk(clk_off), .rst(rst_on), .a(a1), .b(b1), .bin(bin1),
        .Diff(d0), .Borr(br0), .en(en_on),
        .diff_q(dq0), .borr_q(bq0), .out_valid(v0)
    );

    full_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst8), .a(a8), .b(b8), .bin(bin8),
        .Diff(d8), .Borr(br8), .en(en8),
        .diff_q(dq8), .borr_q(bq8), .out_valid(v8)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       b;
        logic       v;
    } reg_t;

    reg_t q1[$];
    reg_t q8[$];
    reg_t st1 = '0;
    reg_t st8 = '0;

    // Reference: {~Borr,Diff} = 2^w + a - b - bin; result {Borr, Diff[7:0]}.
    function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b,
                                           input logic bin, input int w);
        int t;
        int mask;
        logic [8:0] r;
        mask = (1 << w) - 1;
        t = (1 << w) + int'(a & mask[7:0]) - int'(b & mask[7:0]) - int'(bin);
        r[7:0] = 8'(t & mask);
        r[8]   = ~t[w];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one WIDTH=1 step, check combinational outputs, then registered outputs.
    task automatic step1(input logic a, input logic b, input logic bin,
                         input logic en, input logic rst, input string tag);
        logic [8:0] r;
        reg_t       got;
        @(negedge clk);
        a1 = a; b1 = b; bin1 = bin; en1 = en; rst1 = rst;
        r = ref_sub({7'd0, a}, {7'd0, b}, bin, 1);
        if (rst)     st1 = '0;
        else if (en) st1 = '{d: r[7:0], b: r[8], v: 1'b1};
        q1.push_back(st1);
        #2;
        chk({tag, ".diff"}, 32'(d1), 32'(r[0]));
        chk({tag, ".borr"}, 32'(br1), 32'(r[8]));
        chk({tag, ".diff_noclk"}, 32'(d0), 32'(r[0]));
        chk({tag, ".borr_noclk"}, 32'(br0), 32'(r[8]));
        @(posedge clk);
        #1;
        got = q1.pop_front();
        chk({tag, ".diff_q"}, 32'(dq1), 32'(got.d[0]));
        chk({tag, ".borr_q"}, 32'(bq1), 32'(got.b));
        chk({tag, ".out_valid"}, 32'(v1), 32'(got.v));
    endtask

    // Drive one WIDTH=8 step with the same structure.
    task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input logic en, input logic rst, input string tag);
        logic [8:0] r;
        reg_t       got;
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; en8 = en; rst8 = rst;
        r = ref_sub(a, b, bin, 8);
        if (rst)     st8 = '0;
        else if (en) st8 = '{d: r[7:0], b: r[8], v: 1'b1};
        q8.push_back(st8);
        #2;
        chk({tag, ".diff8"}, 32'(d8), 32'(r[7:0]));
        chk({tag, ".borr8"}, 32'(br8), 32'(r[8]));
        @(posedge clk);
        #1;
        got = q8.pop_front();
        chk({tag, ".diff_q8"}, 32'(dq8), 32'(got.d));
        chk({tag, ".borr_q8"}, 32'(bq8), 32'(got.b));
        chk({tag, ".out_valid8"}, 32'(v8), 32'(got.v));
    endtask

    logic [3:0] tv_in  [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [1:0] tv_out [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    initial begin
        a1 = 0; b1 = 0; bin1 = 0; en1 = 0; rst1 = 1;
        a8 = 0; b8 = 0; bin8 = 0; en8 = 0; rst8 = 1;

        // Reset state
        step1(0, 0, 0, 0, 1, "reset1");
        step8(8'h00, 8'h00, 0, 0, 1, "reset8");

        // Exhaustive 1-bit truth table against fixed expected values
        for (int i = 0; i < 8; i++) begin
            logic [3:0] v;
            logic [1:0] o;
            v = tv_in[i];
            o = tv_out[i];
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; bin1 = v[0]; en1 = 0; rst1 = 0;
            #2;
            chk($sformatf("tt%0d.diff", i), 32'(d1), 32'(o[1]));
            chk($sformatf("tt%0d.borr", i), 32'(br1), 32'(o[0]));
            chk($sformatf("tt%0d.diff_noclk", i), 32'(d0), 32'(o[1]));
            chk($sformatf("tt%0d.borr_noclk", i), 32'(br0), 32'(o[0]));
            chk($sformatf("tt%0d.valid_noclk", i), 32'(v0), 32'(0));
        end

        // Registered path: reset, then 0-1-0 captured
        step1(0, 0, 0, 0, 1, "regrst");
        step1(0, 1, 0, 1, 0, "cap01");
        // Hold with changing inputs
        step1(1, 0, 0, 0, 0, "hold_a");
        step1(1, 1, 1, 0, 0, "hold_b");
        step1(0, 0, 1, 1, 0, "cap001");
        // Reset wins over enable
        step1(1, 0, 0, 1, 1, "rst_over_en");
        step1(1, 0, 0, 1, 0, "cap100");
        // Full sweep through the registered path
        for (int i = 0; i < 8; i++)
            step1(i[2], i[1], i[0], 1'b1, 1'b0, $sformatf("sweep%0d", i));

        // WIDTH=8 boundaries
        step8(8'h00, 8'hFF, 1, 1, 0, "wrap");
        step8(8'h80, 8'h7F, 0, 1, 0, "mid");
        step8(8'h5A, 8'h5A, 0, 1, 0, "equal");
        step8(8'hFF, 8'h00, 0, 0, 0, "hold8");
        step8(8'h00, 8'h00, 1, 1, 0, "zero_bin");
        step8(8'h12, 8'h34, 0, 1, 1, "rst8_over_en");

        // WIDTH=8 random vectors with random enable
        for (int i = 0; i < 1000; i++)
            step8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 49) == 0), "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
